// File: rtl/rgbled_chain_ctrl_if.sv
// -----------------------------------------------------------------------------
// rgbled_chain_ctrl_if
// Control/status bundle of the WS281x-style LED chain controller.
//   go_i          frame start request (honoured only while the controller idles)
//   refresh_en_i  continuous refresh: next frame starts as soon as one ends
//   wr_en_i       shadow colour write strobe
//   wr_idx_i      LED index of the write (indices >= NumLeds are dropped)
//   wr_data_i     colour word {G[7:0],R[7:0],B[7:0]}
//   busy_o        controller is not idle
//   frame_done_o  one-cycle pulse on the last cycle of the latch gap
//   dout_o        serial data towards the LED chain, active-high
// The "master" side drives requests and writes; the controller is the "slave".
// -----------------------------------------------------------------------------
interface rgbled_chain_ctrl_if #(
    parameter int IdxW = 2
);
    logic            go_i;
    logic            refresh_en_i;
    logic            wr_en_i;
    logic [IdxW-1:0] wr_idx_i;
    logic [23:0]     wr_data_i;
    logic            busy_o;
    logic            frame_done_o;
    logic            dout_o;

    modport master (
        output go_i, refresh_en_i, wr_en_i, wr_idx_i, wr_data_i,
        input  busy_o, frame_done_o, dout_o
    );

    modport slave (
        input  go_i, refresh_en_i, wr_en_i, wr_idx_i, wr_data_i,
        output busy_o, frame_done_o, dout_o
    );
endinterface

// File: rtl/rgbled_chain_ctrl.sv
// -----------------------------------------------------------------------------
// rgbled_chain_ctrl
// Serial RGB LED chain controller. Every LED has a shadow colour register that
// software may write at any time and an active register that is loaded from the
// shadow copy in the single LOAD cycle at the start of a frame. A frame then
// streams 24 bits per LED (LED 0 first, G7 first) as fixed-period pulses whose
// high time encodes the bit, followed by a low latch gap.
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   bus     rgbled_chain_ctrl_if.slave: go/refresh/shadow-write inputs,
//           busy/frame_done/dout outputs
// Frame length: 1 + 24*NumLeds*BitCycles + ResetCycles clocks.
// -----------------------------------------------------------------------------
module rgbled_chain_ctrl #(
    parameter int NumLeds     = 4,
    parameter int BitCycles   = 32,
    parameter int T0HCycles   = 10,
    parameter int T1HCycles   = 20,
    parameter int ResetCycles = 2000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    rgbled_chain_ctrl_if.slave    bus
);
    localparam int IdxW      = (NumLeds > 1) ? $clog2(NumLeds) : 1;
    localparam int MaxCycles = (BitCycles > ResetCycles) ? BitCycles : ResetCycles;
    localparam int CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    localparam logic [CntW-1:0] BitLast = CntW'(BitCycles - 1);
    localparam logic [CntW-1:0] GapLast = CntW'(ResetCycles - 1);
    localparam logic [CntW-1:0] T0High  = CntW'(T0HCycles);
    localparam logic [CntW-1:0] T1High  = CntW'(T1HCycles);
    localparam logic [IdxW-1:0] LedLast = IdxW'(NumLeds - 1);

    // Pulse timing must leave a distinguishable '0', a longer '1' and a low tail.
    if (!(NumLeds >= 1 && T0HCycles > 0 && T0HCycles < T1HCycles && T1HCycles < BitCycles))
    begin : g_param_check
        $error("rgbled_chain_ctrl: need NumLeds>=1 and 0 < T0HCycles < T1HCycles < BitCycles");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BIT,
        ST_GAP
    } state_t;

    state_t          state_reg, state_next;
    logic [CntW-1:0] cnt_reg, cnt_next;
    logic [IdxW-1:0] led_reg, led_next;
    logic [4:0]      bit_reg, bit_next;
    logic            dout_reg, dout_next;
    logic            load_en;

    logic [23:0]     active_word [NumLeds];
    logic            cur_bit;
    logic [CntW-1:0] high_len;
    logic            last_bit;

    // ---------------------------------------------------------------------
    // Per-LED colour storage. The whole active set must be copied in one
    // cycle, so these are plain registers rather than a RAM.
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NumLeds; gi++) begin : g_led
            logic [23:0] shadow_reg;
            logic [23:0] active_reg;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    shadow_reg <= '0;
                    active_reg <= '0;
                end else begin
                    // Out-of-range indices never match any LED and are dropped.
                    if (bus.wr_en_i && (bus.wr_idx_i == IdxW'(gi))) begin
                        shadow_reg <= bus.wr_data_i;
                    end
                    // Copies the pre-write shadow value: a write landing on the
                    // same edge only reaches the next frame.
                    if (load_en) begin
                        active_reg <= shadow_reg;
                    end
                end
            end

            assign active_word[gi] = active_reg;
        end
    endgenerate

    assign cur_bit  = active_word[led_reg][bit_reg];
    assign high_len = cur_bit ? T1High : T0High;
    assign last_bit = (bit_reg == 5'd0) && (led_reg == LedLast);

    // ---------------------------------------------------------------------
    // Frame sequencer
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            led_reg   <= '0;
            bit_reg   <= '0;
            dout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            led_reg   <= led_next;
            bit_reg   <= bit_next;
            dout_reg  <= dout_next;
        end
    end

    // dout_next is the line level for the cycle that follows, so the pin is
    // driven straight from a flop. Every bit period opens high because
    // T0HCycles > 0, whatever the bit value.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        led_next   = led_reg;
        bit_next   = bit_reg;
        dout_next  = 1'b0;
        load_en    = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (bus.go_i || bus.refresh_en_i) begin
                    state_next = ST_LOAD;
                end
            end

            ST_LOAD: begin
                load_en    = 1'b1;
                led_next   = '0;
                bit_next   = 5'd23;
                cnt_next   = '0;
                state_next = ST_BIT;
                dout_next  = 1'b1;
            end

            ST_BIT: begin
                if (cnt_reg == BitLast) begin
                    cnt_next = '0;
                    if (last_bit) begin
                        state_next = ST_GAP;
                    end else begin
                        dout_next = 1'b1;
                        if (bit_reg == 5'd0) begin
                            bit_next = 5'd23;
                            led_next = led_reg + IdxW'(1);
                        end else begin
                            bit_next = bit_reg - 5'd1;
                        end
                    end
                end else begin
                    cnt_next  = cnt_reg + CntW'(1);
                    dout_next = ((cnt_reg + CntW'(1)) < high_len);
                end
            end

            ST_GAP: begin
                if (cnt_reg == GapLast) begin
                    cnt_next   = '0;
                    state_next = bus.refresh_en_i ? ST_LOAD : ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + CntW'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.dout_o       = dout_reg;
    assign bus.busy_o       = (state_reg != ST_IDLE);
    assign bus.frame_done_o = (state_reg == ST_GAP) && (cnt_reg == GapLast);

endmodule
